// File: rtl/exec_multicycle_sequencer.sv
// rtl/exec_multicycle_sequencer.sv - dual-ALU execute-stage sequencer for the multi-cycle op
//
// Passes single-cycle op pairs straight to ALU1/ALU2. A condition-passed MC_OP in slot 1
// takes over both ALUs for MC_CYCLES cycles. During that time it:
//   - walks a registered iteration counter;
//   - drives the operand-mux selects;
//   - holds decode;
//   - feeds NOOPs into EX/MEM until the final iteration.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   op1_in, op2_in           slot opcodes from DEC/EX
//   pass1, pass2             per-slot condition-check result
//   flush                    branch-taken flush; wins over stall
//   stall                    downstream hold; freezes counter, state and completion count
//   alu_op1, alu_op2         opcodes to ALU1/ALU2
//   cycle_cnt                current MC iteration (0 when idle or on the first iteration)
//   alu1_a_fb, alu1_b_fb     ALU1 A/B operands taken from EX/MEM Rd1/Rd2 feedback
//   alu2_reord               ALU2 operands from the reorder units; also the reorder enable
//   mem_op1, mem_op2         opcodes written into EX/MEM
//   exec_stall               hold DEC/EX and earlier stages
//   illegal_op               MC_OP seen in slot 2 while idle
//   mc_done_cnt              completed MC ops, wrapping

module exec_multicycle_sequencer #(
  parameter logic [4:0] MC_OP     = 5'b01000,
  parameter logic [4:0] NOOP      = 5'b00011,
  parameter int         MC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op1_in,
  input  logic [4:0]  op2_in,
  input  logic        pass1,
  input  logic        pass2,
  input  logic        flush,
  input  logic        stall,
  output logic [4:0]  alu_op1,
  output logic [4:0]  alu_op2,
  output logic [2:0]  cycle_cnt,
  output logic        alu1_a_fb,
  output logic        alu1_b_fb,
  output logic        alu2_reord,
  output logic [4:0]  mem_op1,
  output logic [4:0]  mem_op2,
  output logic        exec_stall,
  output logic        illegal_op,
  output logic [15:0] mc_done_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] LAST_CNT = 3'(MC_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] cnt_nx;
  logic       done_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cycle_cnt   <= 3'd0;
      mc_done_cnt <= 16'd0;
    end else if (flush) begin
      // A flush abandons any in-flight MC op without counting it as done.
      state     <= IDLE;
      cycle_cnt <= 3'd0;
    end else if (!stall) begin
      state     <= state_nx;
      cycle_cnt <= cnt_nx;
      if (done_inc) begin
        mc_done_cnt <= mc_done_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cycle_cnt;
    done_inc   = 1'b0;
    alu_op1    = op1_in;
    alu_op2    = op2_in;
    alu1_a_fb  = 1'b0;
    alu1_b_fb  = 1'b0;
    alu2_reord = 1'b0;
    mem_op1    = NOOP;
    mem_op2    = NOOP;
    exec_stall = 1'b0;
    illegal_op = 1'b0;

    case (state)
      IDLE: begin
        if (op1_in == MC_OP) begin
          // A squashed MC op (pass1=0) leaves the NOOP defaults and stays idle.
          if (pass1) begin
            // Iteration 0: slot 2 is consumed as the MC helper on ALU2.
            alu_op1    = MC_OP;
            alu_op2    = MC_OP;
            alu2_reord = 1'b1;
            exec_stall = 1'b1;
            state_nx   = RUN;
            cnt_nx     = 3'd1;
          end
        end else begin
          mem_op1 = pass1 ? op1_in : NOOP;
          if (op2_in == MC_OP) begin
            illegal_op = 1'b1;
          end else begin
            mem_op2 = pass2 ? op2_in : NOOP;
          end
        end
      end
      RUN: begin
        alu_op1   = MC_OP;
        alu_op2   = NOOP;
        alu1_a_fb = 1'b1;
        // Only the first feedback iteration takes B from Rd2; later ones reuse the partial.
        alu1_b_fb = (cycle_cnt == 3'd1);
        if (cycle_cnt == LAST_CNT) begin
          mem_op1  = MC_OP;
          state_nx = IDLE;
          cnt_nx   = 3'd0;
          done_inc = 1'b1;
        end else begin
          exec_stall = 1'b1;
          cnt_nx     = cycle_cnt + 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase

    if (flush) begin
      mem_op1    = NOOP;
      mem_op2    = NOOP;
      exec_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_multicycle_sequencer.sv
// tb/tb_exec_multicycle_sequencer.sv - scoreboard bench for exec_multicycle_sequencer
module tb_exec_multicycle_sequencer;

  localparam logic [4:0] MC  = 5'b01000;
  localparam logic [4:0] NP  = 5'b00011;
  localparam logic [4:0] ADD = 5'b00001;
  localparam logic [4:0] SUB = 5'b00010;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  op1_in, op2_in;
  logic        pass1, pass2, flush, stall;
  logic [4:0]  alu_op1, alu_op2, mem_op1, mem_op2;
  logic [2:0]  cycle_cnt;
  logic        alu1_a_fb, alu1_b_fb, alu2_reord, exec_stall, illegal_op;
  logic [15:0] mc_done_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] done_exp = 16'd0;
  logic [43:0] sb[$];
  logic [43:0] got, exp_v;

  // Field masks for the packed vector {alu_op1, alu_op2, cnt, a_fb, b_fb, reord, mem1, mem2, stall, illegal, done}
  localparam logic [43:0] ALL_MASK    = {44{1'b1}};
  localparam logic [43:0] NO_ALU_MASK = {10'd0, {34{1'b1}}};

  exec_multicycle_sequencer dut (
    .clk(clk), .rst(rst), .op1_in(op1_in), .op2_in(op2_in), .pass1(pass1), .pass2(pass2),
    .flush(flush), .stall(stall), .alu_op1(alu_op1), .alu_op2(alu_op2), .cycle_cnt(cycle_cnt),
    .alu1_a_fb(alu1_a_fb), .alu1_b_fb(alu1_b_fb), .alu2_reord(alu2_reord), .mem_op1(mem_op1),
    .mem_op2(mem_op2), .exec_stall(exec_stall), .illegal_op(illegal_op), .mc_done_cnt(mc_done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] ev(input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] c,
                                     input logic fa, input logic fb, input logic ro,
                                     input logic [4:0] m1, input logic [4:0] m2,
                                     input logic st, input logic il, input logic [15:0] d);
    return {a1, a2, c, fa, fb, ro, m1, m2, st, il, d};
  endfunction

  function automatic logic [43:0] dut_vec();
    return {alu_op1, alu_op2, cycle_cnt, alu1_a_fb, alu1_b_fb, alu2_reord,
            mem_op1, mem_op2, exec_stall, illegal_op, mc_done_cnt};
  endfunction

  // Drive one cycle of inputs just after the edge, queue its expectation, sample at the negedge.
  task automatic step(input logic [4:0] o1, input logic [4:0] o2, input logic p1, input logic p2,
                      input logic fl, input logic sl, input logic [43:0] e);
    @(posedge clk);
    #1;
    op1_in = o1; op2_in = o2; pass1 = p1; pass2 = p2; flush = fl; stall = sl;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op1_in = ADD; op2_in = SUB; pass1 = 1'b0; pass2 = 1'b0; flush = 1'b0; stall = 1'b0;
    #2;
    sb.push_back(ev(ADD, SUB, 3'd0, 0, 0, 0, NP, NP, 0, 0, 16'd0));
    got = dut_vec(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL reset got %h exp %h", got, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [4:0] o1[3] = '{ADD, SUB, ADD};
    logic [4:0] o2[3] = '{SUB, ADD, ADD};
    logic       p1[3] = '{1'b1, 1'b0, 1'b1};
    logic       p2[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(o1[i], o2[i], p1[i], p2[i], 0, 0,
           ev(o1[i], o2[i], 3'd0, 0, 0, 0, p1[i] ? o1[i] : NP, p2[i] ? o2[i] : NP, 0, 0, done_exp));
      got = dut_vec(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL single_cycle[%0d] got %h exp %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_mc_seq();
    logic [43:0] e[5];
    e[0] = ev(MC, MC, 3'd0, 0, 0, 1, NP, NP, 1, 0, done_exp);
    e[1] = ev(MC, NP, 3'd1, 1, 1, 0, NP, NP, 1, 0, done_exp);
    e[2] = ev(MC, NP, 3'd2, 1, 0, 0, NP, NP, 1, 0, done_exp);
    e[3] = ev(MC, NP, 3'd3, 1, 0, 0, MC, NP, 0, 0, done_exp);
    e[4] = ev(ADD, SUB, 3'd0, 0, 0, 0, ADD, SUB, 0, 0, done_exp + 16'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) step(MC, SUB, 1, 1, 0, 0, e[k]);
      else       step(ADD, SUB, 1, 1, 0, 0, e[k]);
      got = dut_vec(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL mc_seq cyc%0d got %h exp %h", k, got, exp_v);
      end
    end
    done_exp = done_exp + 16'd1;
  endtask

  task automatic test_stall_hold();
    logic [43:0] e[7];
    logic        sl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e[0] = ev(MC, MC, 3'd0, 0, 0, 1, NP, NP, 1, 0, done_exp);
    e[1] = ev(MC, NP, 3'd1, 1, 1, 0, NP, NP, 1, 0, done_exp);
    e[2] = ev(MC, NP, 3'd2, 1, 0, 0, NP, NP, 1, 0, done_exp);
    e[3] = e[2];
    e[4] = e[2];
    e[5] = ev(MC, NP, 3'd3, 1, 0, 0, MC, NP, 0, 0, done_exp);
    e[6] = ev(ADD, SUB, 3'd0, 0, 0, 0, ADD, SUB, 0, 0, done_exp + 16'd1);
    for (int k = 0; k < 7; k++) begin
      if (k < 6) step(MC, SUB, 1, 1, 0, sl[k], e[k]);
      else       step(ADD, SUB, 1, 1, 0, 0, e[k]);
      got = dut_vec(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL stall_hold cyc%0d got %h exp %h", k, got, exp_v);
      end
    end
    done_exp = done_exp + 16'd1;
  endtask

  task automatic test_flush();
    logic [43:0] e[3];
    e[0] = ev(MC, MC, 3'd0, 0, 0, 1, NP, NP, 1, 0, done_exp);
    e[1] = ev(MC, NP, 3'd1, 1, 1, 0, NP, NP, 0, 0, done_exp);
    e[2] = ev(ADD, SUB, 3'd0, 0, 0, 0, ADD, SUB, 0, 0, done_exp);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       step(MC, SUB, 1, 1, 0, 0, e[k]);
        1:       step(MC, SUB, 1, 1, 1, 1, e[k]);
        default: step(ADD, SUB, 1, 1, 0, 0, e[k]);
      endcase
      got = dut_vec(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL flush cyc%0d got %h exp %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_squash();
    for (int k = 0; k < 2; k++) begin
      step(MC, SUB, 0, 1, 0, 0, ev(5'd0, 5'd0, 3'd0, 0, 0, 0, NP, NP, 0, 0, done_exp));
      got = dut_vec() & NO_ALU_MASK; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL squash cyc%0d got %h exp %h", k, got, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    step(ADD, MC, 1, 1, 0, 0, ev(ADD, MC, 3'd0, 0, 0, 0, ADD, NP, 0, 1, done_exp));
    got = dut_vec(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL illegal_pulse got %h exp %h", got, exp_v);
    end
    step(ADD, SUB, 1, 1, 0, 0, ev(ADD, SUB, 3'd0, 0, 0, 0, ADD, SUB, 0, 0, done_exp));
    got = dut_vec(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL illegal_clear got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [43:0] e[3];
    e[0] = ev(MC, MC, 3'd0, 0, 0, 1, NP, NP, 1, 0, done_exp);
    e[1] = ev(MC, NP, 3'd1, 1, 1, 0, NP, NP, 1, 0, done_exp);
    e[2] = ev(MC, NP, 3'd2, 1, 0, 0, NP, NP, 1, 0, done_exp);
    for (int k = 0; k < 3; k++) begin
      step(MC, SUB, 1, 1, 0, 0, e[k]);
      got = dut_vec(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL reset_mid_run pre cyc%0d got %h exp %h", k, got, exp_v);
      end
    end
    // Assert reset between edges: outputs must clear without waiting for a clock.
    #1;
    op1_in = ADD; op2_in = SUB; pass1 = 1'b1; pass2 = 1'b1;
    rst = 1'b1;
    done_exp = 16'd0;
    #1;
    sb.push_back(ev(ADD, SUB, 3'd0, 0, 0, 0, ADD, SUB, 0, 0, done_exp));
    got = dut_vec(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL reset_mid_run async got %h exp %h", got, exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    step(ADD, SUB, 1, 1, 0, 0, ev(ADD, SUB, 3'd0, 0, 0, 0, ADD, SUB, 0, 0, done_exp));
    got = dut_vec(); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin
      errors++; $display("FAIL reset_mid_run post got %h exp %h", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mc_seq();
    test_stall_hold();
    test_flush();
    test_squash();
    test_illegal();
    test_mc_seq();
    test_reset_mid_run();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
    end
    if (ALL_MASK == 44'd0) errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
